classifier_stream_wrapper: RTL and testbench
============================================

CLASSIFIER_STREAM_WRAPPER -- requirements
Module: classifier_stream_wrapper

Interface
REQ-001 Parameter DATA_WIDTH, default 32, AXI-Stream data width in bits; SHALL be a multiple of 8 and at least 32.
REQ-002 Parameter KEEP_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-003 Parameter NUM_CLASSES, default 4, number of class-score words per packet; range 2..65535.
REQ-004 Parameter MODE, default 1: 0 = registered pass-through, 1 = argmax classifier.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 s_axis_tdata  input  DATA_WIDTH  input word; signed two's-complement class score in MODE 1.
REQ-008 s_axis_tkeep  input  KEEP_WIDTH  input byte enables.
REQ-009 s_axis_tvalid  input  1  input word valid.
REQ-010 s_axis_tready  output  1  block accepts input word.
REQ-011 s_axis_tlast  input  1  last word of packet.
REQ-012 m_axis_tdata  output  DATA_WIDTH  output word.
REQ-013 m_axis_tkeep  output  KEEP_WIDTH  output byte enables.
REQ-014 m_axis_tvalid  output  1  output word valid.
REQ-015 m_axis_tready  input  1  downstream accepts output word.
REQ-016 m_axis_tlast  output  1  last word of output packet.

Function
REQ-017 Transfer occurs on either port only in a cycle where tvalid and tready are both 1; m_axis_tvalid, once high, SHALL hold with tdata/tkeep/tlast stable until accepted.
REQ-018 MODE 0: two-entry skid buffer; all outputs registered; latency 1 cycle; sustained 1 word/cycle when m_axis_tready held 1; tdata/tkeep/tlast forwarded unmodified and in order.
REQ-019 MODE 0: s_axis_tready SHALL be registered and deassert only when both skid entries are occupied; no word lost or duplicated under any m_axis_tready pattern.
REQ-020 MODE 1: FSM states ACCUM and EMIT; reset state ACCUM.
REQ-021 ACCUM: s_axis_tready = 1, m_axis_tvalid = 0; each accepted word increments word count (16-bit, saturates at 65535) and compares against running maximum.
REQ-022 First word of a packet SHALL load running max and index 0 unconditionally; word k (0-based) replaces max only when strictly greater (signed), so ties keep the lowest index.
REQ-023 Words with index >= NUM_CLASSES SHALL not update max or index but SHALL be counted.
REQ-024 Accepted word with tlast = 1: ACCUM -> EMIT in next cycle; result word formed from counts including that word.
REQ-025 EMIT: s_axis_tready = 0; m_axis_tvalid = 1; m_axis_tlast = 1; m_axis_tkeep all ones.
REQ-026 Result format: tdata[15:0] = argmax index zero-extended; tdata[30:16] = word count saturated to 15 bits; tdata[DATA_WIDTH-1] = length error; remaining bits 0.
REQ-027 Length error = 1 when packet word count != NUM_CLASSES.
REQ-028 EMIT -> ACCUM on the cycle the result is accepted; count, max and index cleared; next input accepted no earlier than the following cycle.
REQ-029 MODE 1: s_axis_tkeep ignored; one result word per input packet, packets never merged or dropped.
REQ-030 Minimum packet-to-result latency: result valid 1 cycle after tlast accepted.

Reset
REQ-031 While rst = 1: s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, m_axis_tkeep = 0, skid buffer empty, FSM = ACCUM, count/max/index = 0.
REQ-032 Reset asserted mid-packet or mid-EMIT SHALL discard the partial packet or pending result; no output word after release until a new full packet arrives.
REQ-033 s_axis_tready SHALL rise no earlier than the first clock edge after rst deasserts.

Verification
REQ-034 MODE 1, NUM_CLASSES=4, scores 5,-3,9,9 (tlast on 4th), m_axis_tready=1 -> one word 0x0004_0002, tlast=1, 1 cycle after tlast.
REQ-035 MODE 1, packet of 3 words -7,-2,-9 -> 0x8003_0001 (error set, index 1); packet of 6 words max at word 4 -> index = largest of words 0..3, count 6, error set.
REQ-036 MODE 1, m_axis_tready=0 for 10 cycles during EMIT -> tvalid and tdata stable, s_axis_tready=0 throughout, next packet accepted after handshake.
REQ-037 MODE 0, 1000 random words with random tvalid/tready -> output sequence identical to input including tkeep/tlast; full rate when both held 1.
REQ-038 rst pulsed after 2 words of a packet, then full packet 1,2,3,4 -> single result 0x0004_0003, no stale output.

Source files
------------

// File: rtl/classifier_stream_wrapper.sv
// AXI-Stream wrapper: registered skid pass-through (MODE 0) or
// per-packet signed argmax classifier (MODE 1).
//
// Ports:
//   clk, rst             clock, async active-high reset
//   s_axis_*             input stream (tdata/tkeep/tvalid/tready/tlast)
//   m_axis_*             output stream (tdata/tkeep/tvalid/tready/tlast)
//
// MODE 1 result word: [15:0] argmax index, [30:16] word count
// (saturated to 15 bits), [DATA_WIDTH-1] length error.
module classifier_stream_wrapper #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int NUM_CLASSES = 4,
  parameter int MODE        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  generate
    if (MODE == 0) begin : g_skid

      logic [DATA_WIDTH-1:0] out_data;
      logic [KEEP_WIDTH-1:0] out_keep;
      logic                  out_last;
      logic                  out_valid;
      logic [DATA_WIDTH-1:0] skid_data;
      logic [KEEP_WIDTH-1:0] skid_keep;
      logic                  skid_last;
      logic                  skid_valid;
      logic                  rdy;
      logic                  acc;
      logic                  adv;
      logic                  skid_nxt;

      assign acc = s_axis_tvalid && rdy;
      // Output register may take a new word this cycle.
      assign adv = !out_valid || m_axis_tready;
      // Skid only fills when the output register is stalled.
      assign skid_nxt = adv ? 1'b0 : (skid_valid || acc);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_data   <= '0;
          out_keep   <= '0;
          out_last   <= 1'b0;
          out_valid  <= 1'b0;
          skid_data  <= '0;
          skid_keep  <= '0;
          skid_last  <= 1'b0;
          skid_valid <= 1'b0;
          rdy        <= 1'b0;
        end else begin
          if (adv) begin
            if (skid_valid) begin
              out_data  <= skid_data;
              out_keep  <= skid_keep;
              out_last  <= skid_last;
              out_valid <= 1'b1;
            end else begin
              out_valid <= acc;
              if (acc) begin
                out_data <= s_axis_tdata;
                out_keep <= s_axis_tkeep;
                out_last <= s_axis_tlast;
              end
            end
          end else if (acc) begin
            skid_data <= s_axis_tdata;
            skid_keep <= s_axis_tkeep;
            skid_last <= s_axis_tlast;
          end
          skid_valid <= skid_nxt;
          rdy        <= !skid_nxt;
        end
      end

      assign s_axis_tready = rdy;
      assign m_axis_tdata  = out_data;
      assign m_axis_tkeep  = out_keep;
      assign m_axis_tlast  = out_last;
      assign m_axis_tvalid = out_valid;

    end else begin : g_cls

      localparam logic [15:0] NC = 16'(NUM_CLASSES);

      state_t                       state;
      state_t                       state_nxt;
      logic                         en;
      logic [15:0]                  cnt;
      logic [15:0]                  idx;
      logic signed [DATA_WIDTH-1:0] max_q;
      logic [DATA_WIDTH-1:0]        result;
      logic [14:0]                  cnt_sat;
      logic                         acc;
      logic                         done;
      logic                         unused_keep;

      assign unused_keep = ^s_axis_tkeep;
      assign acc  = s_axis_tvalid && s_axis_tready;
      assign done = (state == EMIT) && m_axis_tready;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
      end

      always_comb begin
        state_nxt = state;
        unique case (state)
          ACCUM: if (acc && s_axis_tlast) state_nxt = EMIT;
          EMIT:  if (m_axis_tready)       state_nxt = ACCUM;
        endcase
      end

      always_comb begin
        cnt_sat = cnt[15] ? 15'h7fff : cnt[14:0];
        result = '0;
        result[15:0]         = idx;
        result[30:16]        = cnt_sat;
        result[DATA_WIDTH-1] = (cnt != NC);
      end

      always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tkeep  = '0;
        m_axis_tdata  = '0;
        unique case (state)
          ACCUM: s_axis_tready = en;
          EMIT: begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
            m_axis_tkeep  = '1;
            m_axis_tdata  = result;
          end
        endcase
      end

      // en holds tready low until the first edge after reset release.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          en    <= 1'b0;
          cnt   <= '0;
          idx   <= '0;
          max_q <= '0;
        end else begin
          en <= 1'b1;
          if (done) begin
            cnt   <= '0;
            idx   <= '0;
            max_q <= '0;
          end else if (acc) begin
            if (cnt != 16'hffff) cnt <= cnt + 16'd1;
            if (cnt == 16'd0) begin
              max_q <= s_axis_tdata;
              idx   <= '0;
            end else if (cnt < NC &&
                         $signed(s_axis_tdata) > max_q) begin
              max_q <= s_axis_tdata;
              idx   <= cnt;
            end
          end
        end
      end

    end
  endgenerate

endmodule

// File: tb/tb_classifier_stream_wrapper.sv
// Bench for classifier_stream_wrapper: argmax instance (MODE 1)
// and skid pass-through instance (MODE 0) against a reference model.
module tb_classifier_stream_wrapper;

  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] c_sdata, c_mdata;
  logic [3:0]  c_skeep, c_mkeep;
  logic        c_svalid, c_sready, c_slast;
  logic        c_mvalid, c_mready, c_mlast;

  logic [31:0] p_sdata, p_mdata;
  logic [3:0]  p_skeep, p_mkeep;
  logic        p_svalid, p_sready, p_slast;
  logic        p_mvalid, p_mready, p_mlast;

  classifier_stream_wrapper #(
    .DATA_WIDTH(32), .NUM_CLASSES(NC), .MODE(1)
  ) u_cls (
    .clk(clk), .rst(rst),
    .s_axis_tdata(c_sdata), .s_axis_tkeep(c_skeep),
    .s_axis_tvalid(c_svalid), .s_axis_tready(c_sready),
    .s_axis_tlast(c_slast),
    .m_axis_tdata(c_mdata), .m_axis_tkeep(c_mkeep),
    .m_axis_tvalid(c_mvalid), .m_axis_tready(c_mready),
    .m_axis_tlast(c_mlast)
  );

  classifier_stream_wrapper #(
    .DATA_WIDTH(32), .NUM_CLASSES(NC), .MODE(0)
  ) u_pt (
    .clk(clk), .rst(rst),
    .s_axis_tdata(p_sdata), .s_axis_tkeep(p_skeep),
    .s_axis_tvalid(p_svalid), .s_axis_tready(p_sready),
    .s_axis_tlast(p_slast),
    .m_axis_tdata(p_mdata), .m_axis_tkeep(p_mkeep),
    .m_axis_tvalid(p_mvalid), .m_axis_tready(p_mready),
    .m_axis_tlast(p_mlast)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pkt[$];

  // Argmax over the first NC words, first occurrence wins ties.
  function automatic logic [31:0] model();
    int n, best, lim, sat;
    logic [31:0] r;
    n = pkt.size();
    best = 0;
    lim = (n < NC) ? n : NC;
    sat = (n > 32767) ? 32767 : n;
    for (int i = 1; i < lim; i++)
      if ($signed(pkt[i]) > $signed(pkt[best])) best = i;
    r = '0;
    r[15:0]  = best[15:0];
    r[30:16] = sat[14:0];
    r[31]    = (n != NC);
    return r;
  endfunction

  task automatic send_pkt(input bit gaps, input bit with_last);
    bit hs;
    int t;
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps)
        while ($urandom_range(0, 2) == 0) begin
          c_svalid = 1'b0;
          step();
        end
      c_svalid = 1'b1;
      c_sdata  = pkt[i];
      c_slast  = with_last && (i == pkt.size() - 1);
      c_skeep  = 4'($urandom);
      t = 0;
      do begin
        hs = c_sready;
        step();
        t++;
      end while (!hs && t < 50);
      if (!hs) chk("c_in_timeout", 0, 1);
    end
    c_svalid = 1'b0;
    c_slast  = 1'b0;
    if (with_last) begin
      chk("c_lat_valid", c_mvalid, 1);
      chk("c_emit_sready", c_sready, 0);
    end
  endtask

  task automatic get_result(input logic [31:0] exp, input int hold);
    logic [31:0] d0;
    bit stable;
    stable = 1'b1;
    c_mready = 1'b0;
    d0 = c_mdata;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!c_mvalid || c_mdata !== d0 || c_sready) stable = 1'b0;
    end
    if (hold > 0) chk("c_hold_stable", stable, 1);
    chk("c_result", c_mdata, exp);
    chk("c_tlast", c_mlast, 1);
    chk("c_tkeep", c_mkeep, 4'hf);
    c_mready = 1'b1;
    step();
    c_mready = 1'b0;
    chk("c_after_valid", c_mvalid, 0);
    chk("c_after_sready", c_sready, 1);
  endtask

  logic [36:0] pq[$];
  bit          s_hs, m_hs, held;
  logic [36:0] held_v;
  int          sent, recv;

  task automatic pt_tick();
    logic [36:0] e;
    s_hs = p_svalid && p_sready;
    m_hs = p_mvalid && p_mready;
    if (held)
      chk("pt_stall_hold", {p_mvalid, p_mlast, p_mkeep, p_mdata},
          {1'b1, held_v});
    held   = p_mvalid && !p_mready;
    held_v = {p_mlast, p_mkeep, p_mdata};
    if (m_hs) begin
      if (pq.size() == 0) begin
        chk("pt_spurious", 1, 0);
      end else begin
        e = pq.pop_front();
        chk("pt_word", {p_mlast, p_mkeep, p_mdata}, e);
      end
      recv++;
    end
    if (s_hs) begin
      pq.push_back({p_slast, p_skeep, p_sdata});
      sent++;
    end
    step();
  endtask

  task automatic pt_new_word();
    p_sdata = $urandom;
    p_skeep = 4'($urandom);
    p_slast = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet;
    int cyc, nin, nout, len;
    c_sdata = '0; c_skeep = '0; c_svalid = 0; c_slast = 0; c_mready = 0;
    p_sdata = '0; p_skeep = '0; p_svalid = 0; p_slast = 0; p_mready = 0;
    held = 0;

    rst = 1'b1;
    repeat (3) step();
    chk("rst_c_sready", c_sready, 0);
    chk("rst_c_mvalid", c_mvalid, 0);
    chk("rst_c_mdata", c_mdata, 0);
    chk("rst_c_mkeep", c_mkeep, 0);
    chk("rst_c_mlast", c_mlast, 0);
    chk("rst_p_sready", p_sready, 0);
    chk("rst_p_mvalid", p_mvalid, 0);
    chk("rst_p_mdata", p_mdata, 0);
    rst = 1'b0;
    chk("c_sready_release", c_sready, 0);
    chk("p_sready_release", p_sready, 0);
    step();
    chk("c_sready_up", c_sready, 1);
    chk("p_sready_up", p_sready, 1);

    pkt = '{32'd5, 32'hffff_fffd, 32'd9, 32'd9};
    send_pkt(0, 1);
    get_result(32'h0004_0002, 0);

    pkt = '{32'hffff_fff9, 32'hffff_fffe, 32'hffff_fff7};
    send_pkt(0, 1);
    get_result(32'h8003_0001, 0);

    pkt = '{32'd1, 32'd8, 32'd3, 32'd8, 32'd100, 32'd2};
    send_pkt(1, 1);
    get_result(32'h8006_0001, 0);

    pkt = '{32'd0, 32'd0, 32'd0, 32'd0};
    send_pkt(0, 1);
    get_result(32'h0004_0000, 10);

    for (int k = 0; k < 40; k++) begin
      pkt = {};
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++)
        if ($urandom_range(0, 1) == 1) pkt.push_back($urandom);
        else pkt.push_back(32'($urandom_range(0, 6)) - 32'd3);
      send_pkt(1, 1);
      get_result(model(), $urandom_range(0, 3));
    end

    pkt = '{32'd7, 32'd8};
    send_pkt(0, 0);
    rst = 1'b1;
    step();
    chk("midpkt_rst_mvalid", c_mvalid, 0);
    chk("midpkt_rst_sready", c_sready, 0);
    rst = 1'b0;
    quiet = 1'b1;
    c_mready = 1'b1;
    repeat (5) begin
      step();
      if (c_mvalid) quiet = 1'b0;
    end
    c_mready = 1'b0;
    chk("midpkt_no_stale", quiet, 1);
    pkt = '{32'd1, 32'd2, 32'd3, 32'd4};
    send_pkt(0, 1);
    get_result(32'h0004_0003, 0);

    pkt = '{32'd1, 32'd2, 32'd3, 32'd4};
    send_pkt(0, 1);
    rst = 1'b1;
    step();
    chk("emit_rst_mvalid", c_mvalid, 0);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (4) begin
      step();
      if (c_mvalid) quiet = 1'b0;
    end
    chk("emit_no_stale", quiet, 1);
    pkt = '{32'd3, 32'd1};
    send_pkt(0, 1);
    get_result(32'h8002_0000, 0);

    sent = 0;
    recv = 0;
    cyc = 0;
    p_svalid = 1'b0;
    while ((sent < 1000 || recv < sent) && cyc < 30000) begin
      pt_tick();
      cyc++;
      if (!p_svalid || s_hs) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          p_svalid = 1'b1;
          pt_new_word();
        end else begin
          p_svalid = 1'b0;
        end
      end
      p_mready = ($urandom_range(0, 3) != 0);
    end
    chk("pt_count", recv, 1000);
    chk("pt_drained", pq.size(), 0);

    nin = 0;
    nout = 0;
    p_mready = 1'b1;
    p_svalid = 1'b1;
    pt_new_word();
    for (int i = 0; i < 50; i++) begin
      pt_tick();
      nin += int'(s_hs);
      nout += int'(m_hs);
      if (s_hs) pt_new_word();
    end
    chk("pt_rate_in", nin, 50);
    chk("pt_rate_out", nout, 49);
    p_svalid = 1'b0;
    repeat (3) pt_tick();
    chk("pt_final_drain", pq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
